// File: rtl/data_memory.sv
// Multi-cycle data memory for the RV32IM MA stage: byte/half/word loads and stores
// with a fixed access latency and a combinational stall that freezes the pipeline.
module data_memory #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_req;
    logic           w_access;
    logic           w_do_store;
    logic           w_do_load;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_word;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load_val;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic           w_unused;

    assign w_req      = READ[3] | WRITE[2];
    assign w_idx      = ADDRESS[AW+1:2];
    assign w_access   = (r_state == S_BUSY) && (r_cnt == '0) && !RST;
    assign w_do_store = w_access && WRITE[2];
    assign w_do_load  = w_access && READ[3] && !WRITE[2];
    assign w_unused   = ^ADDRESS[31:AW+2];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req && !RST) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stall output: asserted on the very cycle a request first appears
    always_comb begin
        BUSYWAIT = 1'b0;
        if (!RST) begin
            case (r_state)
                S_IDLE:  BUSYWAIT = w_req;
                S_BUSY:  BUSYWAIT = 1'b1;
                default: BUSYWAIT = 1'b0;
            endcase
        end
    end

    // Latency counter: loaded on acceptance, counts down to the access cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && w_req) begin
            r_cnt <= CW'(LATENCY - 1);
        end else if (r_state == S_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Load lane selection and extension
    always_comb begin
        w_word     = r_mem[w_idx];
        w_byte     = w_word[{ADDRESS[1:0], 3'b000} +: 8];
        w_half     = ADDRESS[1] ? w_word[31:16] : w_word[15:0];
        w_load_val = 32'h0;
        case (READ[2:0])
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_val = w_word;
            3'b100:  w_load_val = {24'h0, w_byte};
            3'b101:  w_load_val = {16'h0, w_half};
            default: w_load_val = 32'h0;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WRITEDATA;
        case (WRITE[1:0])
            2'b00: begin
                w_be    = 4'(4'b0001 << ADDRESS[1:0]);
                w_wdata = {4{WRITEDATA[7:0]}};
            end
            2'b01: begin
                w_be    = ADDRESS[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WRITEDATA[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Storage array; contents survive reset
    always_ff @(posedge CLK) begin
        if (w_do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Load result register; stores leave it untouched
    always_ff @(posedge CLK) begin
        if (RST) begin
            READDATA <= 32'h0;
        end else if (w_do_load) begin
            READDATA <= w_load_val;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Randomized bench for data_memory, checked against an array-based byte-lane model
// plus directed loads/stores, back-to-back accesses, mid-access reset and wrap cases.
module tb_data_memory;

    localparam int unsigned DEPTH_WORDS = 256;
    localparam int unsigned LATENCY     = 2;

    logic        CLK;
    logic        RST;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [3:0]  READ;
    logic [2:0]  WRITE;
    logic [31:0] READDATA;
    logic        BUSYWAIT;

    logic [31:0] mem_m [DEPTH_WORDS];
    logic [31:0] exp_rd;
    int          n_checks;
    int          n_errors;

    data_memory #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ADDRESS  (ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READ     (READ),
        .WRITE    (WRITE),
        .READDATA (READDATA),
        .BUSYWAIT (BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % DEPTH_WORDS;
    endfunction

    function automatic logic [31:0] ld_ref(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] st_ref(input logic [31:0] old, input logic [1:0] f,
                                           input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        logic [31:0] val;
        case (f)
            2'd0: begin
                mask = 32'hFF << (8 * (a % 4));
                val  = (d & 32'hFF) << (8 * (a % 4));
            end
            2'd1: begin
                mask = 32'hFFFF << (16 * ((a / 2) % 2));
                val  = (d & 32'hFFFF) << (16 * ((a / 2) % 2));
            end
            2'd2: begin
                mask = 32'hFFFF_FFFF;
                val  = d;
            end
            default: return old;
        endcase
        return (old & ~mask) | (val & mask);
    endfunction

    // Update the model for one completed access; writes win when both are requested
    task automatic model_apply(input logic [3:0] rd, input logic [2:0] wr,
                               input logic [31:0] a, input logic [31:0] d);
        if (wr[2]) begin
            mem_m[widx(a)] = st_ref(mem_m[widx(a)], wr[1:0], a, d);
        end else if (rd[3]) begin
            exp_rd = ld_ref(mem_m[widx(a)], rd[2:0], a);
        end
    endtask

    // Present one request, measure the stall window, then check the DONE-cycle result
    task automatic access(input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        int busy;
        busy      = 0;
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = a;
        WRITEDATA = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (BUSYWAIT) busy++;
            else break;
        end
        check({tag, "_busy"}, 32'(busy), 32'(LATENCY + 1));
        model_apply(rd, wr, a, d);
        check({tag, "_rd"}, READDATA, exp_rd);
        @(posedge CLK);
        #1;
        READ  = 4'b0;
        WRITE = 3'b0;
    endtask

    logic [31:0] dir_addr [5];
    logic [2:0]  dir_f3   [5];
    logic [31:0] dir_exp  [5];
    logic [31:0] saved;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_rd    = 32'h0;
        RST       = 1'b1;
        READ      = 4'b1010;
        WRITE     = 3'b0;
        ADDRESS   = 32'h10;
        WRITEDATA = 32'h0;

        // Reset with a request present: stall must stay forced low
        repeat (2) begin
            @(negedge CLK);
            check("rst_busy", 32'(BUSYWAIT), 32'h0);
            check("rst_rd", READDATA, 32'h0);
        end
        @(posedge CLK);
        #1;
        READ = 4'b0;
        RST  = 1'b0;
        @(negedge CLK);
        check("idle_busy", 32'(BUSYWAIT), 32'h0);
        @(posedge CLK);
        #1;

        for (int w = 0; w < int'(DEPTH_WORDS); w++) begin
            access(4'b0, 3'b110, 32'(w * 4), $urandom, "init");
        end

        // Directed word and sub-word accesses
        access(4'b0, 3'b110, 32'h10, 32'h8081F2F3, "sw10");
        access(4'b1010, 3'b0, 32'h10, 32'h0, "lw10");
        check("lw10_const", READDATA, 32'h8081F2F3);
        dir_addr[0] = 32'h10; dir_f3[0] = 3'b000; dir_exp[0] = 32'hFFFFFFF3;
        dir_addr[1] = 32'h13; dir_f3[1] = 3'b100; dir_exp[1] = 32'h00000080;
        dir_addr[2] = 32'h12; dir_f3[2] = 3'b001; dir_exp[2] = 32'hFFFF8081;
        dir_addr[3] = 32'h10; dir_f3[3] = 3'b101; dir_exp[3] = 32'h0000F2F3;
        dir_addr[4] = 32'h11; dir_f3[4] = 3'b001; dir_exp[4] = 32'hFFFFF2F3;
        for (int i = 0; i < 5; i++) begin
            access({1'b1, dir_f3[i]}, 3'b0, dir_addr[i], 32'h0, "dld");
            check("dld_const", READDATA, dir_exp[i]);
        end
        access(4'b0, 3'b100, 32'h11, 32'h123456AA, "sb11");
        access(4'b1010, 3'b0, 32'h10, 32'h0, "lw_sb");
        check("lw_sb_const", READDATA, 32'h8081AAF3);
        access(4'b0, 3'b101, 32'h12, 32'h0000BEEF, "sh12");
        access(4'b1010, 3'b0, 32'h10, 32'h0, "lw_sh");
        check("lw_sh_const", READDATA, 32'hBEEFAAF3);

        // Back-to-back identical loads: two windows separated by one DONE cycle
        access(4'b1010, 3'b0, 32'h10, 32'h0, "b2b_a");
        access(4'b1010, 3'b0, 32'h10, 32'h0, "b2b_b");

        // Reset in the second busy cycle of a store abandons it
        saved     = mem_m[widx(32'h20)];
        READ      = 4'b0;
        WRITE     = 3'b110;
        ADDRESS   = 32'h20;
        WRITEDATA = 32'hDEADBEEF;
        @(negedge CLK);
        check("mid_busy0", 32'(BUSYWAIT), 32'h1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_busy", 32'(BUSYWAIT), 32'h0);
        @(posedge CLK);
        #1;
        RST    = 1'b0;
        WRITE  = 3'b0;
        exp_rd = 32'h0;
        @(negedge CLK);
        check("mid_rst_rd", READDATA, 32'h0);
        check("mid_idle_busy", 32'(BUSYWAIT), 32'h0);
        @(posedge CLK);
        #1;
        access(4'b1010, 3'b0, 32'h20, 32'h0, "lw20");
        check("lw20_prior", READDATA, saved);

        // Address wrap and write-over-read priority
        access(4'b0, 3'b110, 32'(4 * DEPTH_WORDS + 32'h10), 32'h5A5A1234, "wrap_sw");
        access(4'b1010, 3'b0, 32'h10, 32'h0, "wrap_lw");
        check("wrap_const", READDATA, 32'h5A5A1234);
        access(4'b1010, 3'b110, 32'h14, 32'hCAFEF00D, "both");
        check("both_rd_hold", READDATA, 32'h5A5A1234);
        access(4'b1010, 3'b0, 32'h14, 32'h0, "both_lw");
        check("both_const", READDATA, 32'hCAFEF00D);

        // Request already present in the cycle reset deasserts
        RST = 1'b1;
        @(posedge CLK);
        #1;
        exp_rd = 32'h0;
        RST    = 1'b0;
        access(4'b1010, 3'b0, 32'h10, 32'h0, "rst_rel");

        // Randomized mix, including undefined load funct3 and no-op store encoding
        for (int n = 0; n < 300; n++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            a  = $urandom;
            case (op)
                0:       access({1'b1, 3'($urandom_range(0, 7))}, 3'b0, a, 32'h0, "rnd_ld");
                1:       access(4'b0, {1'b1, 2'($urandom_range(0, 3))}, a, $urandom, "rnd_st");
                default: access({1'b1, 3'($urandom_range(0, 7))},
                                {1'b1, 2'($urandom_range(0, 3))}, a, $urandom, "rnd_both");
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Data memory for the 5-stage RV32IM pipeline. It sits directly downstream of the core's memory-access (MA) stage and consumes the stage's address, store data and the encoded load/store controls. It returns load data aligned and sign- or zero-extended, ready for the MA/WB register. It models a multi-cycle memory: BUSYWAIT is asserted while an access is pending, which freezes the PC and all pipeline registers.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, ≥ 4.
- LATENCY, 2: cycles spent in BUSY per access; legal range 1–15.

- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; one clock, synchronous, active-high.
- ADDRESS  input  32  byte address from the MA-stage ALU result.
- WRITEDATA  input  32  store data (rs2), right-aligned.
- READ  input  4  [3] = load enable; [2:0] = funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- WRITE  input  3  [2] = store enable; [1:0] = funct3[1:0] (SB 00, SH 01, SW 10).
- READDATA  output  32  extended load result, registered.
- BUSYWAIT  output  1  high = core must stall.

## Operation
- Request: `req = READ[3] | WRITE[2]`.
- Storage: word array, little-endian.
  - Word index = `ADDRESS[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS.
  - Contents are not affected by RST.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - if req and !RST: load counter with LATENCY-1 → BUSY.
    - else stay.
  - BUSY:
    - if counter ≠ 0: decrement, stay.
    - if counter = 0: perform the access → DONE.
  - DONE: → IDLE unconditionally.
- BUSYWAIT = `!RST & ((IDLE & req) | BUSY)`. This is combinational from the request in IDLE, so the stall takes effect on the same edge the request first appears.
- Store (performed on the BUSY→DONE edge):
  - SB writes byte lane `ADDRESS[1:0]`.
  - SH writes lanes `{ADDRESS[1],0}` and `{ADDRESS[1],1}`; `ADDRESS[0]` is ignored.
  - SW writes all four lanes; `ADDRESS[1:0]` is ignored.
  - Unwritten lanes are preserved. WRITE[1:0]=11 performs no write.
- Load (performed on the same edge):
  - The selected lane(s) are extended and registered into READDATA.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
  - Lane selection follows the same rules as stores.
  - Undefined funct3 (011, 110, 111) returns 0.
- READDATA holds its value until the next load completes. Stores do not change READDATA.
- READ[3] and WRITE[2] both high: only the write is performed; READDATA is unchanged.
- Request inputs must stay stable while BUSYWAIT is high (guaranteed by the core stall). Inputs are sampled when the access is performed.
- Back-to-back requests: in DONE, BUSYWAIT is low, so the core advances. The next request is seen in the following IDLE cycle, even if it is identical to the previous one.

## Timing
- Reset values: state = IDLE, counter = 0, READDATA = 0x00000000, BUSYWAIT = 0. BUSYWAIT is also forced to 0 throughout RST.
- Access sequence, with the request first seen in cycle t:
  - BUSYWAIT is high in cycles t … t+LATENCY.
  - The access is performed on the edge ending cycle t+LATENCY.
  - DONE occupies cycle t+LATENCY+1: BUSYWAIT is low and READDATA is valid.
  - The core captures READDATA into MA/WB on the edge ending that cycle.
- Stall per access: LATENCY+1 cycles. Occupancy: LATENCY+2 cycles. With the default LATENCY=2: 3 stall cycles.
- No request: BUSYWAIT stays 0 and there is zero added latency.
- RST asserted mid-access (BUSY or DONE): next state is IDLE. A pending store is abandoned with no partial write; READDATA becomes 0.
- Request present in the cycle RST deasserts: it is accepted normally starting in that cycle.

## Test plan
- Reset, then SW addr 0x10, data 0x8081F2F3 → BUSYWAIT high for exactly 3 cycles, low in the 4th. A following LW 0x10 returns 0x8081F2F3 in its DONE cycle.
- Loads of that word:
  - LB 0x10 → 0xFFFFFFF3
  - LBU 0x13 → 0x00000080
  - LH 0x12 → 0xFFFF8081
  - LHU 0x10 → 0x0000F2F3
  - LH 0x11 → 0xFFFFF2F3 (`ADDRESS[0]` ignored)
- SB 0x11 data 0x123456AA, then LW 0x10 → 0x8081AAF3. SH 0x12 data 0x0000BEEF, then LW 0x10 → 0xBEEFAAF3.
- Back-to-back identical LW 0x10: two separate busy windows of 3 cycles each, separated by one DONE cycle with BUSYWAIT low. READDATA is valid in both DONE cycles.
- Reset mid-access:
  - Issue SW 0x20 data 0xDEADBEEF and assert RST in the 2nd busy cycle → state IDLE, BUSYWAIT 0, READDATA 0.
  - A subsequent LW 0x20 returns the prior contents, not 0xDEADBEEF.
- Wrap and priority:
  - SW to byte address 4·DEPTH_WORDS+0x10 (0x410), then LW 0x10 → same data.
  - Both READ[3] and WRITE[2] high → the write occurs and READDATA is unchanged.
